instr_fetch_queue: RTL and testbench

Front-end fetch stage that sits directly upstream of the decode/register-read logic: it walks the program counter, requests instruction words from a variable-latency instruction memory over a req/gnt/rvalid handshake, buffers returned words with their PCs in a small FIFO, and presents them downstream with valid/ready. It replaces the fixed PC→instruction-memory path so the datapath can stall on the memory and accept branch/jump redirects that flush stale fetches.

---
 rtl/instr_fetch_queue.sv | 106 ++++++++++
 tb/tb_instr_fetch_queue.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - PC walker with req/gnt/rvalid fetch and a small instruction FIFO
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  output logic                     imem_req_o,
  output logic [31:0]              imem_addr_o,
  input  logic                     imem_gnt_i,
  input  logic                     imem_rvalid_i,
  input  logic [31:0]              imem_rdata_i,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_pc_i,
  output logic                     instr_valid_o,
  output logic [31:0]              instr_o,
  output logic [31:0]              instr_pc_o,
  input  logic                     instr_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t        r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [31:0]   r_instr_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_room;
  logic w_room_after_push;

  assign w_push            = (r_state == S_WAIT) && imem_rvalid_i && !redirect_i;
  assign w_pop             = (r_count != '0) && instr_ready_i && !redirect_i;
  // Room checks deliberately ignore a same-cycle pop to keep the issue path short.
  assign w_room            = r_count < L_DEPTH;
  assign w_room_after_push = (r_count + 1'b1) < L_DEPTH;

  assign imem_req_o    = (r_state == S_REQ);
  assign imem_addr_o   = r_fetch_pc;
  assign instr_valid_o = (r_count != '0);
  assign instr_o       = r_instr_mem[r_rd_ptr];
  assign instr_pc_o    = r_pc_mem[r_rd_ptr];
  assign count_o       = r_count;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (redirect_i) begin
      r_fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      // A granted-but-unanswered request must be absorbed before refetching.
      case (r_state)
        S_REQ:             r_state <= imem_gnt_i ? S_DISCARD : (start_i ? S_REQ : S_IDLE);
        S_WAIT, S_DISCARD: r_state <= imem_rvalid_i ? (start_i ? S_REQ : S_IDLE) : S_DISCARD;
        default:           r_state <= start_i ? S_REQ : S_IDLE;
      endcase
    end else begin
      if (w_push) begin
        r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
        r_instr_mem[r_wr_ptr] <= imem_rdata_i;
        r_wr_ptr              <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

      case (r_state)
        S_IDLE: begin
          if (start_i && w_room) r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem_gnt_i) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid_i) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
            r_state    <= (start_i && w_room_after_push) ? S_REQ : S_IDLE;
          end
        end
        S_DISCARD: begin
          if (imem_rvalid_i) r_state <= start_i ? S_REQ : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - scoreboard bench for instr_fetch_queue
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int gnt_count = 0;
  int gnt_dly = 0;
  int rv_dly = 1;
  int req_cnt = 0;
  int rv_wait = 0;
  bit pending = 1'b0;
  bit prev_wait = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] prev_addr = 32'h0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  instr_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rvalid), .imem_rdata_i(rdata),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
    .instr_ready_i(ready), .count_o(count)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0050_0093;
      32'h8:   return 32'h00a0_0113;
      default: return {a[27:0], 4'h3};
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [31:0] base, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      a = base + 32'(4 * i);
      exp_q.push_back({a, word_of(a)});
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int n;
    start = 1'b0;
    ready = 1'b1;
    for (n = 0; n < 300; n++) begin
      step();
      if (!imem_req && count == 3'd0 && !pending) break;
    end
    chk("drain_idle", {31'b0, (!imem_req && count == 3'd0 && !pending)}, 32'd1);
    exp_q.delete();
    ready = 1'b0;
  endtask

  task automatic wait_consumed(input string name, input int target);
    int n;
    for (n = 0; n < 400 && consumed < target; n++) step();
    chk(name, {31'b0, consumed >= target}, 32'd1);
  endtask

  // Memory model: drives at posedge+1, sees the previous cycle's stimulus.
  always @(posedge clk) begin
    #1;
    gnt    = 1'b0;
    rvalid = 1'b0;
    if (!rst_n) begin
      pending   = 1'b0;
      req_cnt   = 0;
      prev_wait = 1'b0;
    end else begin
      if (pending) begin
        rv_wait--;
        if (rv_wait <= 0) begin
          rvalid  = 1'b1;
          rdata   = word_of(pend_addr);
          pending = 1'b0;
        end
      end
      if (prev_wait && imem_req && !redirect) begin
        checks++;
        if (imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL addr_stable actual=%h required=%h", imem_addr, prev_addr);
        end
      end
      if (imem_req) begin
        if (pending) begin
          errors++;
          $display("FAIL req_outstanding actual=1 required=0");
        end
        if (req_cnt >= gnt_dly) begin
          gnt       = 1'b1;
          pending   = 1'b1;
          rv_wait   = rv_dly;
          pend_addr = imem_addr;
          req_cnt   = 0;
          prev_wait = 1'b0;
          gnt_count++;
        end else begin
          req_cnt++;
          prev_wait = 1'b1;
          prev_addr = imem_addr;
        end
      end else begin
        req_cnt   = 0;
        prev_wait = 1'b0;
      end
    end
  end

  // Monitor: compares every consumed head entry against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && instr_valid && ready && !redirect) begin
      checks++;
      consumed++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%h_%h required=none", instr_pc, instr);
      end else begin
        mon_e = exp_q.pop_front();
        if ({instr_pc, instr} !== mon_e) begin
          errors++;
          $display("FAIL pop_entry actual=%h_%h required=%h_%h", instr_pc, instr, mon_e[63:32], mon_e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int c0;
    int g0;
    #3;
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);
    chk("rst_count", {29'b0, count}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Sequential fetch, then fill the FIFO with ready low.
    preload(32'h0, 16);
    start = 1'b1;
    step();
    chk("first_req", {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    chk("wait_valid", {31'b0, instr_valid}, 32'd0);
    step();
    chk("first_valid", {31'b0, instr_valid}, 32'd1);
    chk("first_pc", instr_pc, 32'h0);
    chk("first_instr", instr, 32'h0000_0013);
    chk("next_req", {31'b0, imem_req}, 32'd1);
    for (n = 0; n < 100 && count != 3'd4; n++) step();
    chk("full_count", {29'b0, count}, 32'd4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("full_noreq", {31'b0, imem_req}, 32'd0);
      chk("full_hold", {29'b0, count}, 32'd4);
    end
    ready = 1'b1;
    step();
    ready = 1'b0;
    for (n = 0; n < 4 && !imem_req; n++) step();
    chk("refill_req", {31'b0, imem_req}, 32'd1);
    chk("refill_addr", imem_addr, 32'h10);
    ready = 1'b1;
    wait_consumed("seq_consumed", 6);
    drain();

    // Slow grant: request must hold steady for five cycles.
    gnt_dly = 5;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0200;
    start = 1'b1;
    ready = 1'b1;
    preload(32'h200, 16);
    step();
    redirect = 1'b0;
    chk("slow_addr", imem_addr, 32'h200);
    chk("slow_req", {31'b0, imem_req}, 32'd1);
    c0 = consumed;
    wait_consumed("slow_consumed", c0 + 3);
    drain();
    gnt_dly = 0;

    // Redirect while a response is outstanding.
    rv_dly = 4;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0040;
    start = 1'b1;
    ready = 1'b0;
    preload(32'h40, 4);
    g0 = gnt_count;
    step();
    redirect = 1'b0;
    for (n = 0; n < 100 && gnt_count < g0 + 2; n++) step();
    step();
    chk("pre_redir_count", {29'b0, count}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0103;
    preload(32'h100, 8);
    step();
    redirect = 1'b0;
    chk("redir_count", {29'b0, count}, 32'd0);
    chk("redir_valid", {31'b0, instr_valid}, 32'd0);
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_discard", {31'b0, imem_req}, 32'd0);
    ready = 1'b1;
    c0 = consumed;
    wait_consumed("redir_consumed", c0 + 2);
    drain();
    rv_dly = 1;

    // PC wrap through the top of the address space.
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    start = 1'b1;
    ready = 1'b1;
    preload(32'hFFFF_FFF8, 12);
    step();
    redirect = 1'b0;
    c0 = consumed;
    wait_consumed("wrap_consumed", c0 + 4);
    drain();

    // Redirect coincident with an arriving word and a pop.
    redirect = 1'b1;
    redirect_pc = 32'h0000_0300;
    start = 1'b1;
    ready = 1'b0;
    preload(32'h300, 4);
    step();
    redirect = 1'b0;
    for (n = 0; n < 100 && count != 3'd2; n++) step();
    chk("coinc_fill", {29'b0, count}, 32'd2);
    for (n = 0; n < 20 && !rvalid; n++) step();
    chk("coinc_rvalid", {31'b0, rvalid}, 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h0000_0402;
    ready = 1'b1;
    preload(32'h400, 8);
    step();
    redirect = 1'b0;
    chk("coinc_count", {29'b0, count}, 32'd0);
    chk("coinc_valid", {31'b0, instr_valid}, 32'd0);
    chk("coinc_addr", imem_addr, 32'h400);
    chk("coinc_req", {31'b0, imem_req}, 32'd1);
    c0 = consumed;
    wait_consumed("coinc_consumed", c0 + 2);
    drain();

    // Asynchronous reset in the middle of a fetch.
    rv_dly = 3;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0500;
    start = 1'b1;
    ready = 1'b0;
    preload(32'h500, 4);
    step();
    redirect = 1'b0;
    for (n = 0; n < 100 && count != 3'd1; n++) step();
    g0 = gnt_count;
    for (n = 0; n < 100 && gnt_count == g0; n++) step();
    step();
    rst_n = 1'b0;
    #1;
    chk("arst_req", {31'b0, imem_req}, 32'd0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_valid", {31'b0, instr_valid}, 32'd0);
    chk("arst_instr", instr, 32'h0);
    chk("arst_pc", instr_pc, 32'h0);
    chk("arst_count", {29'b0, count}, 32'd0);
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    rv_dly = 1;
    ready = 1'b1;
    preload(32'h0, 8);
    step();
    chk("restart_req", {31'b0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'h0);
    c0 = consumed;
    wait_consumed("restart_consumed", c0 + 3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
